nubus_arb_ctrl: RTL and testbench

NUBUS_ARB_CTRL -- requirements
Module: nubus_arb_ctrl

---
 rtl/nubus_arb_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_nubus_arb_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_arb_ctrl.sv
// -----------------------------------------------------------------------------
// nubus_arb_ctrl
//
// NuBus-style distributed arbitration controller for one card. The card asks
// for the bus on the shared request line, competes on the open-drain
// arbitration lines with its static ID, waits for the current transaction to
// finish, and then owns the bus until the local master releases it. An
// optional fairness hold-off keeps a card that just released the bus from
// re-arbitrating until every other pending requester has been served (seen
// as the request line going high).
//
// Parameters
//   ID_WIDTH   : width of the card ID and arbitration lines (2..8)
//   ARB_CYCLES : clocks the arbitration lines settle before sampling (1..15)
//   FAIR       : 1 enables the fairness hold-off, 0 disables it
//
// Ports
//   nub_clk      in   sole clock, rising edge
//   nub_reset    in   asynchronous, active-high reset
//   nub_idn      in   card ID, active-low, static
//   nub_arbn_i   in   sampled arbitration lines, active-low
//   nub_arbn_oe  out  pull-low enables for the arbitration lines (combinational)
//   nub_rqstn_i  in   sampled request line, active-low
//   nub_rqstn_oe out  pull-low enable for the request line
//   nub_startn_i in   sampled start line, active-low (new arbitration chance)
//   bus_idle_i   in   no transaction in progress
//   req_i        in   local master wants the bus
//   lock_i       in   keep ownership after req_i drops
//   grant_o      out  card owns the bus
//   busy_o       out  controller is not idle
// -----------------------------------------------------------------------------
module nubus_arb_ctrl #(
  parameter int ID_WIDTH   = 4,
  parameter int ARB_CYCLES = 2,
  parameter int FAIR       = 1
) (
  input  logic                nub_clk,
  input  logic                nub_reset,
  input  logic [ID_WIDTH-1:0] nub_idn,
  input  logic [ID_WIDTH-1:0] nub_arbn_i,
  output logic [ID_WIDTH-1:0] nub_arbn_oe,
  input  logic                nub_rqstn_i,
  output logic                nub_rqstn_oe,
  input  logic                nub_startn_i,
  input  logic                bus_idle_i,
  input  logic                req_i,
  input  logic                lock_i,
  output logic                grant_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOST,
    WAIT_BUS,
    OWNED
  } state_t;

  // Settle counter reload value; the counter is 4 bits and is reloaded on
  // every entry to ARB, so it only ever counts down from here to zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(ARB_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          settle_q, settle_d;
  logic                grant_q, grant_d;
  logic                rqstn_q, rqstn_d;
  logic                fair_hold_q, fair_hold_d;
  logic                busy_q, busy_d;

  logic                arbcy;
  logic                won;
  logic                abort;
  logic                blocked;
  logic [ID_WIDTH-1:0] arb_pull;

  // ---------------------------------------------------------------------------
  // Arbitration network
  // ---------------------------------------------------------------------------
  assign arbcy = (state_q == ARB);

  // Walk from the most significant line down. Once any higher line is seen
  // pulled where our own ID bit is 0, a card with a larger ID is competing and
  // we release every lower line.
  // NOTE: blocking assignments are correct in combinational logic; 'blocked'
  // must update within the same pass so each lower bit sees the bits above it.
  always_comb begin
    blocked  = 1'b0;
    arb_pull = '0;
    for (int k = ID_WIDTH - 1; k >= 0; k--) begin
      arb_pull[k] = arbcy & ~nub_idn[k] & ~blocked;
      blocked     = blocked | (nub_idn[k] & ~nub_arbn_i[k]);
    end
  end

  // We win when no line carries a 1 where our ID carries a 0.
  assign won         = arbcy & ~|(nub_idn & ~nub_arbn_i);
  assign nub_arbn_oe = arb_pull;

  // Dropping req_i while still competing or waiting backs out unconditionally
  // and outranks every other transition out of those states.
  assign abort = ~req_i & ((state_q == ARB) | (state_q == LOST) | (state_q == WAIT_BUS));

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    grant_d     = grant_q;
    rqstn_d     = rqstn_q;
    // A high request line means nobody is waiting, so the hold-off ends.
    fair_hold_d = fair_hold_q & ~nub_rqstn_i;

    if (abort) begin
      state_d = IDLE;
      rqstn_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i && !fair_hold_q) begin
            state_d  = ARB;
            settle_d = SETTLE_LOAD;
            rqstn_d  = 1'b1;
          end
        end

        ARB: begin
          if (settle_q == 4'd0) begin
            state_d = won ? WAIT_BUS : LOST;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end

        LOST: begin
          // Keep requesting; retry at the next start-of-transaction.
          if (!nub_startn_i) begin
            state_d  = ARB;
            settle_d = SETTLE_LOAD;
          end
        end

        WAIT_BUS: begin
          // Take the bus and release the request line in the same edge.
          if (bus_idle_i) begin
            state_d = OWNED;
            grant_d = 1'b1;
            rqstn_d = 1'b0;
          end
        end

        OWNED: begin
          if (!req_i && !lock_i) begin
            state_d = IDLE;
            grant_d = 1'b0;
            // Setting the hold-off wins over a same-edge clear.
            if (FAIR != 0) begin
              fair_hold_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          grant_d = 1'b0;
          rqstn_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      state_q     <= IDLE;
      settle_q    <= 4'd0;
      grant_q     <= 1'b0;
      rqstn_q     <= 1'b0;
      fair_hold_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      grant_q     <= grant_d;
      rqstn_q     <= rqstn_d;
      fair_hold_q <= fair_hold_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign nub_rqstn_oe = rqstn_q;

endmodule

// File: tb/tb_nubus_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nubus_arb_ctrl
//
// Three controllers share the bus-side control inputs:
//   inst 0: ID_WIDTH=4, ARB_CYCLES=2, FAIR=1, nub_idn=4'h5
//   inst 1: ID_WIDTH=4, ARB_CYCLES=3, FAIR=0, nub_idn=4'h9
//   inst 2: ID_WIDTH=6, ARB_CYCLES=2, FAIR=1, nub_idn=6'h3E
// Each has its own arbitration lines, formed from the reference model's pulls
// plus an optional external competitor and re-sampled once per clock.
// -----------------------------------------------------------------------------
module tb_nubus_arb_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_ARB  = 1;
  localparam int P_LOST = 2;
  localparam int P_WAIT = 3;
  localparam int P_OWN  = 4;

  typedef struct {
    int phase;
    int settled;   // clocks already spent settling in the current attempt
    bit grant;
    bit req_pull;
    bit hold;
  } model_t;

  // ins = {req, lock, idle, startn, rqstn}; outs = {grant, busy, rqstn_oe}
  typedef struct {
    logic [4:0] ins;
    logic [3:0] ext;
    logic [2:0] outs;
    logic [3:0] oe;
  } vec_t;

  logic       nub_clk = 1'b0;
  logic       nub_reset;
  logic       req, lock, idle, startn, rqstn;

  logic [7:0] idn_v  [3];
  logic [7:0] arbn_v [3];
  logic [7:0] ext_v  [3];

  logic [3:0] arbn0, oe0, arbn1, oe1;
  logic [5:0] arbn2, oe2;
  logic       grant0, busy0, rq0, grant1, busy1, rq1, grant2, busy2, rq2;

  model_t     m [3];
  int         n_checks = 0;
  int         n_errors = 0;

  assign arbn0 = arbn_v[0][3:0];
  assign arbn1 = arbn_v[1][3:0];
  assign arbn2 = arbn_v[2][5:0];

  always #5 nub_clk = ~nub_clk;

  nubus_arb_ctrl #(.ID_WIDTH(4), .ARB_CYCLES(2), .FAIR(1)) u_dut0 (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .nub_idn(4'h5), .nub_arbn_i(arbn0),
    .nub_arbn_oe(oe0), .nub_rqstn_i(rqstn), .nub_rqstn_oe(rq0), .nub_startn_i(startn),
    .bus_idle_i(idle), .req_i(req), .lock_i(lock), .grant_o(grant0), .busy_o(busy0));

  nubus_arb_ctrl #(.ID_WIDTH(4), .ARB_CYCLES(3), .FAIR(0)) u_dut1 (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .nub_idn(4'h9), .nub_arbn_i(arbn1),
    .nub_arbn_oe(oe1), .nub_rqstn_i(rqstn), .nub_rqstn_oe(rq1), .nub_startn_i(startn),
    .bus_idle_i(idle), .req_i(req), .lock_i(lock), .grant_o(grant1), .busy_o(busy1));

  nubus_arb_ctrl #(.ID_WIDTH(6), .ARB_CYCLES(2), .FAIR(1)) u_dut2 (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .nub_idn(6'h3E), .nub_arbn_i(arbn2),
    .nub_arbn_oe(oe2), .nub_rqstn_i(rqstn), .nub_rqstn_oe(rq2), .nub_startn_i(startn),
    .bus_idle_i(idle), .req_i(req), .lock_i(lock), .grant_o(grant2), .busy_o(busy2));

  // ---------------------------------------------------------------------------
  // Instance description and DUT observation helpers
  // ---------------------------------------------------------------------------
  function automatic int w_of(input int i);
    return (i == 2) ? 6 : 4;
  endfunction

  function automatic int ac_of(input int i);
    return (i == 1) ? 3 : 2;
  endfunction

  function automatic bit fair_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [7:0] mask_of(input int i);
    logic [7:0] mk = '0;
    for (int k = 0; k < w_of(i); k++) mk[k] = 1'b1;
    return mk;
  endfunction

  function automatic logic [7:0] dut_oe(input int i);
    case (i)
      0:       return {4'h0, oe0};
      1:       return {4'h0, oe1};
      default: return {2'b00, oe2};
    endcase
  endfunction

  function automatic logic grant_of(input int i);
    case (i)
      0:       return grant0;
      1:       return grant1;
      default: return grant2;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic rq_of(input int i);
    case (i)
      0:       return rq0;
      1:       return rq1;
      default: return rq2;
    endcase
  endfunction

  function automatic logic [7:0] z(input logic b);
    return {7'b0, b};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Find the highest line where another card shows a 1 against our 0; we
  // keep pulling only our 1-bits above it.
  function automatic logic [7:0] pulls(input bit arbcy, input logic [7:0] idn,
                                       input logic [7:0] arbn, input int w);
    int         top = -1;
    logic [7:0] p   = '0;
    for (int k = 0; k < w; k++) if (idn[k] && !arbn[k]) top = k;
    if (arbcy) for (int k = top + 1; k < w; k++) p[k] = ~idn[k];
    return p;
  endfunction

  function automatic bit no_loss(input logic [7:0] idn, input logic [7:0] arbn, input int w);
    for (int k = 0; k < w; k++) if (idn[k] && !arbn[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.phase    = P_IDLE;
    r.settled  = 0;
    r.grant    = 1'b0;
    r.req_pull = 1'b0;
    r.hold     = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input int arb_cycles, input bit fair,
                                        input bit won, input bit rq, input bit lk, input bit idl,
                                        input bit start_low, input bit rqstn_high);
    model_t n = c;
    if (rqstn_high) n.hold = 1'b0;
    if (!rq && (c.phase == P_ARB || c.phase == P_LOST || c.phase == P_WAIT)) begin
      n.phase    = P_IDLE;
      n.req_pull = 1'b0;
    end else begin
      case (c.phase)
        P_IDLE: if (rq && !c.hold) begin
          n.phase = P_ARB; n.settled = 0; n.req_pull = 1'b1;
        end
        P_ARB: begin
          if (c.settled == arb_cycles - 1) n.phase = won ? P_WAIT : P_LOST;
          else n.settled = c.settled + 1;
        end
        P_LOST: if (start_low) begin
          n.phase = P_ARB; n.settled = 0;
        end
        P_WAIT: if (idl) begin
          n.phase = P_OWN; n.grant = 1'b1; n.req_pull = 1'b0;
        end
        P_OWN: if (!rq && !lk) begin
          n.phase = P_IDLE; n.grant = 1'b0;
          if (fair) n.hold = 1'b1;
        end
        default: n = model_reset();
      endcase
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and sequencing tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i);
    logic [7:0] exp_oe;
    exp_oe = pulls(m[i].phase == P_ARB, idn_v[i], arbn_v[i], w_of(i));
    check($sformatf("inst%0d grant", i), z(grant_of(i)), z(m[i].grant));
    check($sformatf("inst%0d busy", i), z(busy_of(i)), z(m[i].phase != P_IDLE));
    check($sformatf("inst%0d rqstn_oe", i), z(rq_of(i)), z(m[i].req_pull));
    check($sformatf("inst%0d arbn_oe", i), dut_oe(i), exp_oe);
  endtask

  // Re-sample each bus: model pulls plus external competitor, active-low.
  task automatic refresh_lines();
    logic [7:0] p;
    for (int i = 0; i < 3; i++) begin
      p         = pulls(m[i].phase == P_ARB, idn_v[i], arbn_v[i], w_of(i));
      arbn_v[i] = ~((p | ext_v[i]) & mask_of(i));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic tick();
    bit won;
    refresh_lines();
    @(posedge nub_clk);
    for (int i = 0; i < 3; i++) begin
      won  = no_loss(idn_v[i], arbn_v[i], w_of(i));
      m[i] = model_step(m[i], ac_of(i), fair_of(i), won, req, lock, idle, !startn, rqstn);
    end
    @(negedge nub_clk);
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic do_reset();
    nub_reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset inst%0d arbn_oe", i), dut_oe(i), 8'h00);
      check($sformatf("reset inst%0d grant", i), z(grant_of(i)), 8'h00);
      check($sformatf("reset inst%0d busy", i), z(busy_of(i)), 8'h00);
      check($sformatf("reset inst%0d rqstn_oe", i), z(rq_of(i)), 8'h00);
      m[i] = model_reset();
    end
    #1;
    nub_reset = 1'b0;
  endtask

  task automatic wait_for_grant(input int i, input int limit, input string name);
    int n = 0;
    while (!grant_of(i) && n < limit) begin
      tick();
      n++;
    end
    check(name, z(grant_of(i)), 8'h01);
  endtask

  task automatic set_quiet();
    req = 1'b0; lock = 1'b0; idle = 1'b1; startn = 1'b1; rqstn = 1'b1;
    for (int i = 0; i < 3; i++) ext_v[i] = 8'h00;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vecs [23];

  initial begin
    // Instance 0 expectations, derived by hand from the protocol rules.
    vecs[0]  = '{5'b10111, 4'h0, 3'b011, 4'hA};  // IDLE -> ARB, settle 1
    vecs[1]  = '{5'b10111, 4'h0, 3'b011, 4'hA};  // settle 0
    vecs[2]  = '{5'b10111, 4'h0, 3'b011, 4'h0};  // won -> WAIT_BUS
    vecs[3]  = '{5'b10111, 4'h0, 3'b110, 4'h0};  // OWNED, 4th edge, rqstn released
    vecs[4]  = '{5'b01111, 4'h0, 3'b110, 4'h0};  // lock holds ownership
    vecs[5]  = '{5'b00110, 4'h0, 3'b000, 4'h0};  // release, hold-off set
    vecs[6]  = '{5'b10110, 4'h0, 3'b000, 4'h0};  // hold-off ignores req
    vecs[7]  = '{5'b10111, 4'h0, 3'b000, 4'h0};  // rqstn high clears hold-off
    vecs[8]  = '{5'b10111, 4'h0, 3'b011, 4'hA};  // now arbitrates
    vecs[9]  = '{5'b00111, 4'h0, 3'b000, 4'h0};  // abort, no hold-off
    vecs[10] = '{5'b10111, 4'hC, 3'b011, 4'h8};  // re-arbitrate vs ID C
    vecs[11] = '{5'b10111, 4'hC, 3'b011, 4'h8};
    vecs[12] = '{5'b10111, 4'hC, 3'b011, 4'h0};  // lost
    vecs[13] = '{5'b10111, 4'hC, 3'b011, 4'h0};  // stays LOST
    vecs[14] = '{5'b10101, 4'h0, 3'b011, 4'hA};  // start -> ARB
    vecs[15] = '{5'b10111, 4'h0, 3'b011, 4'hA};
    vecs[16] = '{5'b10111, 4'h0, 3'b011, 4'h0};  // won
    vecs[17] = '{5'b10011, 4'h0, 3'b011, 4'h0};  // bus busy, keep waiting
    vecs[18] = '{5'b10111, 4'h0, 3'b110, 4'h0};  // OWNED
    vecs[19] = '{5'b00111, 4'h0, 3'b000, 4'h0};  // release; set beats clear
    vecs[20] = '{5'b10111, 4'h0, 3'b000, 4'h0};  // still held off
    vecs[21] = '{5'b10111, 4'h0, 3'b011, 4'hA};
    vecs[22] = '{5'b00111, 4'h0, 3'b000, 4'h0};

    idn_v[0] = 8'h05; idn_v[1] = 8'h09; idn_v[2] = 8'h3E;
    for (int i = 0; i < 3; i++) begin
      arbn_v[i] = 8'hFF;
      m[i]      = model_reset();
    end
    set_quiet();
    nub_reset = 1'b1;
    repeat (2) @(negedge nub_clk);
    do_reset();

    // Table-driven directed sequence on instance 0.
    for (int v = 0; v < 23; v++) begin
      {req, lock, idle, startn, rqstn} = vecs[v].ins;
      ext_v[0] = {4'h0, vecs[v].ext};
      tick();
      check($sformatf("vec%0d grant", v), z(grant0), z(vecs[v].outs[2]));
      check($sformatf("vec%0d busy", v), z(busy0), z(vecs[v].outs[1]));
      check($sformatf("vec%0d rqstn_oe", v), z(rq0), z(vecs[v].outs[0]));
      check($sformatf("vec%0d arbn_oe", v), {4'h0, oe0}, {4'h0, vecs[v].oe});
    end

    // Fairness off versus on after a release with the request line held low.
    set_quiet();
    do_reset();
    req = 1'b1;
    wait_for_grant(0, 10, "fair own0");
    wait_for_grant(1, 10, "fair own1");
    req = 1'b0; rqstn = 1'b0;
    tick();
    check("fair release0", z(busy0), 8'h00);
    check("fair release1", z(busy1), 8'h00);
    req = 1'b1;
    tick();
    check("fair hold0", z(busy0), 8'h00);
    check("no fair hold1", z(busy1), 8'h01);
    rqstn = 1'b1;
    tick();
    check("fair clear edge0", z(busy0), 8'h00);
    tick();
    check("fair rearb0", z(busy0), 8'h01);

    // Contested arbitration: ID 6 against an external pull on bit 3.
    set_quiet();
    do_reset();
    ext_v[1] = 8'h08; req = 1'b1;
    tick();
    check("contest arb oe", dut_oe(1), 8'h00);
    check("contest arb busy", z(busy1), 8'h01);
    repeat (3) tick();
    check("contest lost busy", z(busy1), 8'h01);
    check("contest lost rqstn", z(rq1), 8'h01);
    check("contest lost grant", z(grant1), 8'h00);
    ext_v[1] = 8'h00; startn = 1'b0;
    tick();
    check("contest restart oe", dut_oe(1), 8'h06);
    startn = 1'b1;
    wait_for_grant(1, 10, "contest grant");

    // Six-bit IDs: ID 1 against an external pull on bit 5 never drives or wins.
    set_quiet();
    do_reset();
    ext_v[2] = 8'h20; req = 1'b1;
    tick();
    check("w6 arb oe", dut_oe(2), 8'h00);
    check("w6 arb busy", z(busy2), 8'h01);
    repeat (5) tick();
    check("w6 no grant", z(grant2), 8'h00);
    check("w6 still requesting", z(rq2), 8'h01);

    // Reset in mid-arbitration (settle count 1) and in mid-ownership.
    set_quiet();
    do_reset();
    req = 1'b1;
    tick();
    check("midarb busy", z(busy0), 8'h01);
    check("midarb oe", dut_oe(0), 8'h0A);
    do_reset();
    req = 1'b0;
    tick();
    check("post reset idle", z(busy0), 8'h00);
    req = 1'b1;
    tick();
    check("post reset first edge", z(busy0), 8'h01);
    wait_for_grant(0, 10, "midown grant");
    do_reset();
    req = 1'b0;
    tick();
    check("post reset no grant", z(grant0), 8'h00);

    // Randomized traffic against the reference model.
    set_quiet();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req    = ($urandom_range(0, 9) < 8);
      lock   = ($urandom_range(0, 3) == 0);
      idle   = ($urandom_range(0, 3) != 0);
      startn = ($urandom_range(0, 2) != 0);
      rqstn  = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < 3; i++)
        ext_v[i] = ($urandom_range(0, 3) == 0) ? (8'($urandom) & mask_of(i)) : 8'h00;
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
